regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_arbiter_if.sv | 37 +++
 rtl/rr_picker.sv | 34 +++
 rtl/regfile_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, FSM states and the registered access bundle
// for the register-file port arbiter.
package regfile_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] wdata;
    } rf_req_t;

    // Index width that stays legal when only one requester exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester-side bundle: per-requester request lanes plus
// one-hot acceptance/completion pulses and shared read data.
interface regfile_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2
) ();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*REG_DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [REG_DATA_W-1:0]         rsp_rdata;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

endinterface

// File: rtl/rr_picker.sv
// Round-robin pick: first valid requester above last_i,
// wrapping from the top index back to zero.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic found;
    int   cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_i) + k) % NUM_REQ;
            if (!found && valid_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IDX_W'(cand);
            end
        end
    end

    assign any_o = |valid_i;

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one register-file port among NUM_REQ requesters;
// each access takes an ISSUE cycle then a RESP cycle.
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_arbiter_if.slave      bus,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic                  rf_write,
    output logic [REG_DATA_W-1:0] rf_wdata,
    input  logic [REG_DATA_W-1:0] rf_rdata
);

    localparam int IDX_W = idx_w(NUM_REQ);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [NUM_REQ-1:0]    ready_q, ready_d;
    logic [NUM_REQ-1:0]    rsp_q, rsp_d;
    logic [REG_DATA_W-1:0] rdata_q, rdata_d;
    rf_req_t               rf_q, rf_d;

    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    rf_req_t               sel;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid_i (bus.req_valid),
        .last_i  (last_q),
        .grant_o (grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Grant is one-hot, so a plain overwrite acts as the lane mux.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel.write = bus.req_write[i];
                sel.addr  = bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                sel.wdata = bus.req_wdata[i*REG_DATA_W +: REG_DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        ready_d     = '0;
        rsp_d       = '0;
        rdata_d     = rdata_q;
        rf_d        = rf_q;
        rf_d.write  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                if (pick_any) begin
                    state_d = ST_ISSUE;
                    last_d  = pick_idx;
                    ready_d = grant;
                    rf_d    = sel;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
                rsp_d   = ready_q;
                rdata_d = rf_q.write ? '0 : rf_rdata;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            ready_q <= '0;
            rsp_q   <= '0;
            rdata_q <= '0;
            rf_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            rsp_q   <= rsp_d;
            rdata_q <= rdata_d;
            rf_q    <= rf_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_q;
    assign bus.rsp_rdata = rdata_q;
    assign rf_addr       = rf_q.addr;
    assign rf_write      = rf_q.write;
    assign rf_wdata      = rf_q.wdata;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed and randomized checks of regfile_arbiter against
// a transaction-level arbitration and memory model.
module tb_regfile_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 2;

    logic        clk;
    logic        rst;
    logic [3:0]  rf_addr;
    logic        rf_write;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;
    logic [31:0] rf_mem [16];

    int n_assert = 0;
    int n_fail   = 0;

    logic [NREQ-1:0] pend_v, pv, exp_ready, exp_rsp;
    logic            pend_w [NREQ];
    logic [3:0]      pend_a [NREQ];
    logic [31:0]     pend_d [NREQ];
    logic [31:0]     mem_ref [16];
    logic [31:0]     exp_rdata;
    logic            can_arb;
    int              ptr, w;
    int              waits [NREQ];

    regfile_arbiter_if #(.NUM_REQ(NREQ)) bus_if ();

    regfile_arbiter #(.NUM_REQ(NREQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .rf_addr  (rf_addr),
        .rf_write (rf_write),
        .rf_wdata (rf_wdata),
        .rf_rdata (rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External register file: writes at posedge, read data settles at negedge.
    always @(posedge clk) if (rf_write === 1'b1) rf_mem[rf_addr] <= rf_wdata;
    always @(negedge clk) rf_rdata <= rf_mem[rf_addr];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic wr,
                           input logic [3:0] a, input logic [31:0] d);
        bus_if.req_valid[i]          = v;
        bus_if.req_write[i]          = wr;
        bus_if.req_addr[i*4 +: 4]    = a;
        bus_if.req_wdata[i*32 +: 32] = d;
    endtask

    task automatic clear_all();
        bus_if.req_valid = '0;
        bus_if.req_write = '0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
    endtask

    // Leaves rst high at a negedge; caller releases it.
    task automatic rst_on();
        @(negedge clk);
        clear_all();
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with the arbiter free to grant next edge.
    task automatic single(input int i, input logic wr, input logic [3:0] a,
                          input logic [31:0] d, input logic [31:0] exp,
                          input string tag);
        set_req(i, 1'b1, wr, a, d);
        @(negedge clk);
        chk({tag, ".ready"}, 32'(bus_if.req_ready), 32'(1 << i));
        chk({tag, ".rf_write"}, 32'(rf_write), 32'(wr));
        chk({tag, ".rf_addr"}, 32'(rf_addr), 32'(a));
        set_req(i, 1'b0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk({tag, ".rsp"}, 32'(bus_if.rsp_valid), 32'(1 << i));
        chk({tag, ".rdata"}, bus_if.rsp_rdata, exp);
    endtask

    function automatic int winner(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (p + k) % NREQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    initial begin
        rst = 1'b0;
        clear_all();
        for (int i = 0; i < 16; i++) rf_mem[i] = '0;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst.ready", 32'(bus_if.req_ready), 32'h0);
        chk("rst.rsp", 32'(bus_if.rsp_valid), 32'h0);
        chk("rst.rf_write", 32'(rf_write), 32'h0);
        chk("rst.rf_addr", 32'(rf_addr), 32'h0);
        chk("rst.rf_wdata", rf_wdata, 32'h0);
        chk("rst.rdata", bus_if.rsp_rdata, 32'h0);
        rst = 1'b0;

        // Write then read back through requester 0.
        single(0, 1'b1, 4'd3, 32'hDEADBEEF, 32'h0, "wr3");
        single(0, 1'b0, 4'd3, 32'h0, 32'hDEADBEEF, "rd3");
        @(negedge clk);
        chk("idle.rsp", 32'(bus_if.rsp_valid), 32'h0);
        chk("idle.ready", 32'(bus_if.req_ready), 32'h0);

        // Same-cycle read and write after reset: requester 0 wins first.
        single(0, 1'b1, 4'd15, 32'h1234, 32'h0, "pre15");
        rst_on();
        set_req(1, 1'b1, 1'b1, 4'd15, 32'h1);
        set_req(0, 1'b1, 1'b0, 4'd15, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("race.ready0", 32'(bus_if.req_ready), 32'h1);
        set_req(0, 1'b0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("race.rsp0", 32'(bus_if.rsp_valid), 32'h1);
        chk("race.rdata0", bus_if.rsp_rdata, 32'h1234);
        @(negedge clk);
        chk("race.ready1", 32'(bus_if.req_ready), 32'h2);
        set_req(1, 1'b0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("race.rsp1", 32'(bus_if.rsp_valid), 32'h2);
        chk("race.rdata1", bus_if.rsp_rdata, 32'h0);
        single(0, 1'b0, 4'd15, 32'h0, 32'h1, "rd15");

        // Both requesters valid from reset: grants alternate 0,1,0,1.
        rst_on();
        set_req(0, 1'b1, 1'b0, 4'd3, 32'h0);
        set_req(1, 1'b1, 1'b0, 4'd15, 32'h0);
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("alt.ready", 32'(bus_if.req_ready),
                (j % 2 == 0) ? ((j % 4 == 0) ? 32'h1 : 32'h2) : 32'h0);
            chk("alt.onehot", 32'($onehot0(bus_if.req_ready)), 32'h1);
            chk("alt.rsp", 32'(bus_if.rsp_valid),
                (j % 2 == 1) ? ((j % 4 == 1) ? 32'h1 : 32'h2) : 32'h0);
            if (j % 2 == 1)
                chk("alt.rdata", bus_if.rsp_rdata,
                    (j % 4 == 1) ? 32'hDEADBEEF : 32'h1);
        end
        clear_all();

        // Reset during a write's ISSUE cycle must drop it.
        rst_on();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b1, 4'd5, 32'h55);
        @(negedge clk);
        chk("abort.rf_write", 32'(rf_write), 32'h1);
        set_req(0, 1'b0, 1'b0, 4'h0, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("abort.rf_write_low", 32'(rf_write), 32'h0);
        chk("abort.ready_low", 32'(bus_if.req_ready), 32'h0);
        chk("abort.rf_wdata", rf_wdata, 32'h0);
        @(negedge clk);
        chk("abort.rsp_in_rst", 32'(bus_if.rsp_valid), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort.rsp", 32'(bus_if.rsp_valid), 32'h0);
        single(0, 1'b0, 4'd5, 32'h0, 32'h0, "rd5");

        // One request held for six edges: grants on every other edge.
        rst_on();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 4'd3, 32'h0);
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            chk("hold.ready", 32'(bus_if.req_ready),
                (j == 0 || j == 2 || j == 4) ? 32'h1 : 32'h0);
            chk("hold.rsp", 32'(bus_if.rsp_valid),
                (j == 1 || j == 3 || j == 5) ? 32'h1 : 32'h0);
            if (j == 1 || j == 3 || j == 5)
                chk("hold.rdata", bus_if.rsp_rdata, 32'hDEADBEEF);
            if (j == 5) set_req(0, 1'b0, 1'b0, 4'h0, 32'h0);
        end

        // Randomized traffic against the transaction model.
        rst_on();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mem_ref[i] = rf_mem[i];
        ptr       = NREQ - 1;
        can_arb   = 1'b1;
        exp_rsp   = '0;
        exp_rdata = '0;
        pend_v    = '0;
        for (int i = 0; i < NREQ; i++) begin
            waits[i]  = 0;
            pend_w[i] = 1'b0;
            pend_a[i] = '0;
            pend_d[i] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_v[i] && $urandom_range(0, 99) < 50) begin
                    pend_v[i] = 1'b1;
                    pend_w[i] = 1'($urandom_range(0, 1));
                    pend_a[i] = 4'($urandom_range(0, 15));
                    pend_d[i] = $urandom;
                end
                set_req(i, pend_v[i], pend_w[i], pend_a[i], pend_d[i]);
            end
            pv = pend_v;
            @(negedge clk);
            exp_ready = '0;
            w = -1;
            if (can_arb && pv != '0) begin
                w = winner(pv, ptr);
                exp_ready[w] = 1'b1;
            end
            chk("rnd.ready", 32'(bus_if.req_ready), 32'(exp_ready));
            chk("rnd.rsp", 32'(bus_if.rsp_valid), 32'(exp_rsp));
            if (exp_rsp != '0) chk("rnd.rdata", bus_if.rsp_rdata, exp_rdata);
            exp_rsp = exp_ready;
            if (w >= 0) begin
                exp_rdata = pend_w[w] ? 32'h0 : mem_ref[pend_a[w]];
                if (pend_w[w]) mem_ref[pend_a[w]] = pend_d[w];
                chk("rnd.starve", 32'(waits[w] <= NREQ - 1), 32'h1);
                waits[w] = 0;
                for (int i = 0; i < NREQ; i++)
                    if (i != w && pv[i]) waits[i]++;
                ptr = w;
                pend_v[w] = 1'b0;
            end
            can_arb = (exp_ready == '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
